mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares one single-port unified memory between the CPU's instruction-fetch path and its load/store path. It sits between the PC/fetch logic and the data path on one side and the unified memory on the other. It sequences every access through a small FSM, returns read data with a one-cycle valid pulse, and drives the PC hold signal that freezes the processor while either access is outstanding. Data accesses have priority; a starvation counter guarantees fetch progress.

## Interface
- STARVE_MAX, 4: maximum consecutive data grants allowed while a fetch is pending (≥1).
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request, level; held with if_addr stable until if_valid.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word, registered.
- if_valid  out  1  one-cycle pulse: if_rdata valid, fetch complete.
- d_req  in  1  data request, level; held with d_we/d_addr/d_wdata stable until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, registered.
- d_valid  out  1  one-cycle pulse: access complete.
- mem_en  out  1  memory access strobe, held for the whole access.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word address to memory (bits [1:0] forced 0).
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  read data from memory, sampled when mem_ready=1.
- mem_ready  in  1  memory completion, one cycle.
- pc_hold  out  1  freeze PC/pipeline register.

## Operation
- States: IDLE, IF_ACC, D_ACC (2-bit).
- IDLE, grant decision (port masked if its valid is high this cycle): d_req and not (starve_cnt==STARVE_MAX and if_req) → D_ACC; else if_req → IF_ACC; else stay.
- Grant registers address/we/wdata into memory-side outputs; mem_en=1 for every cycle in IF_ACC/D_ACC.
- IF_ACC/D_ACC: wait for mem_ready; on mem_ready capture mem_rdata into if_rdata (IF) or d_rdata (D loads only; store leaves d_rdata unchanged), pulse matching valid next cycle, go IDLE.
- mem_ready in IDLE ignored.
- starve_cnt: on D grant with if_req high → increment, saturating at STARVE_MAX; on IF grant → 0; otherwise unchanged.
- pc_hold = (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
- mem_we=0 in IF_ACC and IDLE; mem_wdata don't-care unless mem_we.

## Timing
- Reset (async, immediate): state IDLE, mem_en/mem_we/if_valid/d_valid=0, mem_addr/mem_wdata/if_rdata/d_rdata=0, starve_cnt=0. Access in flight abandoned; no valid is ever produced for it.
- Latency: request seen in IDLE cycle t → mem_en from t+1 → mem_ready at t+k (k≥1) → valid at t+k+1, state IDLE at t+k+1. Minimum request-to-valid latency is 2 cycles.
- Valid cycle is itself an IDLE cycle with that port masked; the other port can be granted in it. Back-to-back same-port requests therefore have a throughput of one per 3 cycles minimum.
- Simultaneous if_req and d_req: D wins unless starve_cnt==STARVE_MAX.
- Requests dropped mid-access: access still completes and valid still pulses.

## Structure
- Shared package mem_arbiter_pkg: state localparams ARB_IDLE=2'b00, ARB_IF=2'b01, ARB_D=2'b10; default STARVE_MAX.
- Single module; no sub-module. The grant decision is an inline combinational block feeding the FSM register.

## Test plan
- Reset mid-D_ACC (mem_en=1), RST_N low → all outputs 0 asynchronously; later mem_ready → no valid.
- Lone fetch if_addr=0x0000_0006, memory returns 0x2008_0005 after k=3 → mem_addr=0x0000_0004, if_valid at t+4 with if_rdata=0x2008_0005, pc_hold high t..t+3.
- Store d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF, k=1 → mem_we=1 at t+1, d_valid at t+2, d_rdata unchanged.
- Simultaneous if_req/d_req, STARVE_MAX=4, d_req reasserted continuously → grant order D,D,D,D,IF, starve_cnt then 0.
- Load at 0x20 (k=1) followed by fetch pending → D valid cycle grants IF (mem_en re-asserted the next cycle, mem_addr=fetch address).
- mem_ready pulse in IDLE → no state change, no valid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg : FSM state encodings and defaults shared by the arbiter.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'b00;
  localparam logic [1:0] ARB_IF   = 2'b01;
  localparam logic [1:0] ARB_D    = 2'b10;

  localparam int STARVE_MAX_DEFAULT = 4;

  // Width needed to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : fetch/load-store arbiter for one single-port unified memory.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        pc_hold
);

  localparam int              c_cnt_w = cnt_width(STARVE_MAX);
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(STARVE_MAX);

  logic [1:0]         r_state;
  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               w_if_pend;
  logic               w_d_pend;
  logic               w_starved;
  logic               w_grant_if;
  logic               w_grant_d;
  logic               w_unused_addr_bits;

  // A port whose valid is pulsing is finishing, not requesting again.
  assign w_if_pend = if_req & ~if_valid;
  assign w_d_pend  = d_req & ~d_valid;
  assign w_starved = (r_starve_cnt == c_max) & if_req;

  always_comb begin
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    if (r_state == ARB_IDLE) begin
      if (w_d_pend && !w_starved) begin
        w_grant_d = 1'b1;
      end else if (w_if_pend) begin
        w_grant_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_starve_cnt <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      if_valid     <= 1'b0;
      d_valid      <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_d) begin
            r_state   <= ARB_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= {d_addr[31:2], 2'b00};
            mem_wdata <= d_wdata;
            if (if_req && (r_starve_cnt != c_max)) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else if (w_grant_if) begin
            r_state      <= ARB_IF;
            mem_en       <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= {if_addr[31:2], 2'b00};
            r_starve_cnt <= '0;
          end
        end
        ARB_IF: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            mem_en   <= 1'b0;
            r_state  <= ARB_IDLE;
          end
        end
        ARB_D: begin
          if (mem_ready) begin
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
            d_valid <= 1'b1;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_hold = (if_req & ~if_valid) | (d_req & ~d_valid);

  // Memory is word-addressed; the byte offset is intentionally dropped.
  assign w_unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : scoreboard bench for mem_arbiter with a latency-programmable
// memory responder. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        pc_hold;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Responder: returns resp_data ^ mem_addr after lat cycles of mem_en.
  int          lat = 1;
  bit          resp_en = 1'b1;
  logic [31:0] resp_data = '0;
  int          rcnt = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_hold(pc_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (mem_ready) begin
      mem_ready = 1'b0;
      rcnt = 0;
    end else if (mem_en && resp_en) begin
      rcnt++;
      if (rcnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = resp_data ^ mem_addr;
      end
    end
  end

  // Scoreboard check on every valid pulse.
  always @(negedge clk) begin
    if (rst_n && (if_valid || d_valid)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_valid: if_valid=%b d_valid=%b, required no valid", if_valid, d_valid);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (if_valid !== !e.is_d || d_valid !== e.is_d ||
            (e.is_d ? d_rdata : if_rdata) !== e.data) begin
          miscompares++;
          $display("FAIL sb_valid: if_valid=%b d_valid=%b data=%h, required port=%s data=%h",
                   if_valid, d_valid, e.is_d ? d_rdata : if_rdata, e.is_d ? "D" : "IF", e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({mem_en, mem_we, if_valid, d_valid, pc_hold} !== 5'b0 ||
        {mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h rd=%h/%h, required all 0",
               mem_en, mem_we, mem_addr, if_rdata, d_rdata);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_after_release: mem_en=%b, required 0", mem_en);
    end
  endtask

  task automatic test_reset_mid_access();
    resp_en = 1'b0;
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    tick();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL rst_mid_grant: mem_en=%b mem_addr=%h, required 1 / 00000040", mem_en, mem_addr);
    end
    d_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_en, mem_we, if_valid, d_valid} !== 4'b0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_async: mem_en=%b mem_addr=%h, required 0 / 0 before clock edge", mem_en, mem_addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    #2 mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (d_valid !== 1'b0 || mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_abandon: d_valid=%b mem_en=%b, required 0 / 0", d_valid, mem_en);
      end
    end
    rcnt = 0;
    resp_en = 1'b1;
  endtask

  task automatic test_fetch();
    int n;
    lat = 3;
    resp_data = 32'h2008_0005 ^ 32'h4;
    exp_q.push_back('{is_d: 1'b0, data: 32'h2008_0005});
    if_addr = 32'h6; if_req = 1'b1;
    #1;
    vectors++;
    if (pc_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_hold_t: pc_hold=%b, required 1", pc_hold);
    end
    tick();
    n = 1;
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h4 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_mem: en=%b addr=%h we=%b, required 1 / 00000004 / 0", mem_en, mem_addr, mem_we);
    end
    while (!if_valid && n < 10) begin
      vectors++;
      if (pc_hold !== 1'b1) begin
        miscompares++;
        $display("FAIL fetch_hold: pc_hold=%b at t+%0d, required 1", pc_hold, n);
      end
      tick();
      n++;
    end
    vectors++;
    if (if_valid !== 1'b1 || n != 4) begin
      miscompares++;
      $display("FAIL fetch_latency: if_valid=%b at t+%0d, required 1 at t+4", if_valid, n);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_load_then_fetch();
    int n;
    lat = 1;
    resp_data = 32'hCAFE_0001 ^ 32'h20;
    exp_q.push_back('{is_d: 1'b1, data: 32'hCAFE_0001});
    exp_q.push_back('{is_d: 1'b0, data: 32'h0BAD_0002});
    d_we = 1'b0; d_addr = 32'h20; d_req = 1'b1;
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL load_grant: en=%b addr=%h we=%b, required 1 / 00000020 / 0", mem_en, mem_addr, mem_we);
    end
    tick();
    vectors++;
    if (d_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL load_valid: d_valid=%b at t+2, required 1", d_valid);
    end
    d_req = 1'b0;
    resp_data = 32'h0BAD_0002 ^ 32'h100;
    tick();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_after_load: en=%b addr=%h we=%b, required 1 / 00000100 / 0", mem_en, mem_addr, mem_we);
    end
    n = 0;
    while (!if_valid && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fetch_after_load_timeout: if_valid=%b after %0d cycles, required 1", if_valid, n);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_store();
    lat = 1;
    exp_q.push_back('{is_d: 1'b1, data: 32'hCAFE_0001});
    d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
    tick();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL store_mem: en=%b we=%b addr=%h wdata=%h, required 1 / 1 / 00000010 / deadbeef",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hCAFE_0001 || pc_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL store_valid: d_valid=%b d_rdata=%h pc_hold=%b, required 1 / cafe0001 / 0",
               d_valid, d_rdata, pc_hold);
    end
    d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_idle_ready();
    #2 mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (mem_en !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0 ||
        if_rdata !== 32'h0BAD_0002 || d_rdata !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL idle_ready: en=%b ifv=%b dv=%b if_rdata=%h d_rdata=%h, required 0/0/0/0bad0002/cafe0001",
               mem_en, if_valid, d_valid, if_rdata, d_rdata);
    end
  endtask

  task automatic test_starvation();
    bit   grants[$];
    bit   seen_if;
    logic prev_en;
    int   n;
    lat = 1;
    resp_data = 32'h1234_0000;
    for (int i = 0; i < 4; i++) exp_q.push_back('{is_d: 1'b1, data: 32'h1234_0300});
    exp_q.push_back('{is_d: 1'b0, data: 32'h1234_0200});
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    if_addr = 32'h200; if_req = 1'b1;
    seen_if = 1'b0;
    prev_en = 1'b0;
    n = 0;
    while (n < 80) begin
      tick();
      n++;
      if (mem_en && !prev_en) begin
        grants.push_back(mem_addr == 32'h300);
        if (mem_addr != 32'h300) begin
          seen_if = 1'b1;
          d_req = 1'b0;
        end
      end
      // Fetch steps aside in each D valid cycle so D keeps winning until starved.
      if (!seen_if) if_req = !d_valid;
      if (if_valid) break;
      prev_en = mem_en;
    end
    if_req = 1'b0;
    vectors++;
    if (grants.size() != 5 || grants[0] != 1'b1 || grants[1] != 1'b1 ||
        grants[2] != 1'b1 || grants[3] != 1'b1 || grants[4] != 1'b0) begin
      miscompares++;
      $display("FAIL starve_order: %0d grants, first five D-flags=%b%b%b%b%b, required 5 grants D,D,D,D,IF",
               grants.size(), grants.size() > 0 ? grants[0] : 1'bx, grants.size() > 1 ? grants[1] : 1'bx,
               grants.size() > 2 ? grants[2] : 1'bx, grants.size() > 3 ? grants[3] : 1'bx,
               grants.size() > 4 ? grants[4] : 1'bx);
    end
    tick();
    // Counter must be back at 0: a fresh simultaneous request goes to D again.
    exp_q.push_back('{is_d: 1'b1, data: 32'h1234_0300});
    exp_q.push_back('{is_d: 1'b0, data: 32'h1234_0200});
    d_req = 1'b1; if_req = 1'b1;
    tick();
    vectors++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h300) begin
      miscompares++;
      $display("FAIL starve_reset: en=%b addr=%h, required 1 / 00000300 (D wins)", mem_en, mem_addr);
    end
    tick();
    d_req = 1'b0;
    n = 0;
    while (!if_valid && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (if_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_tail_timeout: if_valid=%b, required 1 within 10 cycles", if_valid);
    end
    if_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_fetch();
    test_load_then_fetch();
    test_store();
    test_idle_ready();
    test_starvation();
    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d expected results never produced, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
